dot_accum: RTL and testbench

- Downstream stage of the 16-lane int8 dot-product MAC.
- Consumes the MAC's 20-bit per-beat partial sums and accumulates a configurable number of beats into one long-vector dot product (K = 16 × beats).
- Buffers finished results in a small FIFO and offers them to the consumer over a valid/ready handshake.
- The MAC cannot stall, so this block has no input ready; it flags results lost to backpressure.

---
 rtl/dot_accum.sv | 119 +++++++++++
 tb/tb_dot_accum.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accum.sv
// Accumulates N beats of MAC partial sums into one dot product; DOTACC_SAT_EN selects saturating adds.
// Latency: the final beat at edge T gives out_valid with that result at T+1 when the FIFO was empty.
// No input stall: a result that arrives while the FIFO is full and not popping is dropped and sets sticky ovf.
module dot_accum #(
  parameter int IN_W       = 20,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_sum,
  input  logic [7:0]                    cfg_beats,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic                          busy,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ACC_W-1:0] acc;
  logic [8:0]       beat_cnt;
  logic [8:0]       n_lat;
  logic [ACC_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             accept;
  logic             first;
  logic [8:0]       n_eff;
  logic [8:0]       cnt_inc;
  logic             last;
  logic [ACC_W-1:0] addend;
  logic [ACC_W:0]   raw_sum;
  logic [ACC_W-1:0] sum;
  logic             pop;
  logic             full;
  logic             do_push;
  logic             drop;

  always_comb begin
    accept  = in_valid & ~clear;
    first   = (beat_cnt == 9'd0);
    // The beat count is taken from cfg_beats only on the first beat; later beats use the latched copy.
    n_eff   = first ? ((cfg_beats == 8'd0) ? 9'd256 : {1'b0, cfg_beats}) : n_lat;
    cnt_inc = beat_cnt + 9'd1;
    last    = accept & (cnt_inc == n_eff);
    addend  = first ? '0 : acc;
    raw_sum = {1'b0, addend} + (ACC_W+1)'(in_sum);
`ifdef DOTACC_SAT_EN
    sum     = raw_sum[ACC_W] ? '1 : raw_sum[ACC_W-1:0];
`else
    sum     = raw_sum[ACC_W-1:0];
`endif
    pop     = out_valid & out_ready;
    full    = (fifo_cnt == CW'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    do_push = last & (~full | pop);
    drop    = last & full & ~pop;
  end

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      n_lat    <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (clear) begin
        acc      <= '0;
        beat_cnt <= '0;
        busy     <= 1'b0;
        ovf      <= 1'b0;
      end else if (accept) begin
        acc      <= sum;
        beat_cnt <= last ? 9'd0 : cnt_inc;
        busy     <= ~last;
        if (first) begin
          n_lat <= n_eff;
        end
        if (drop) begin
          ovf <= 1'b1;
        end
      end

      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (!do_push && pop) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  // Storage needs no reset: out_data is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= sum;
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Drives a 32-bit and a 20-bit accumulator with the same stimulus and checks both against a queue model.
module tb_dot_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [19:0] in_sum;
  logic [7:0]  cfg_beats;
  logic        clear;
  logic        out_ready;

  logic        ov32, busy32, ovf32;
  logic [31:0] od32;
  logic [2:0]  fc32;
  logic        ov20, busy20, ovf20;
  logic [19:0] od20;
  logic [2:0]  fc20;

  dot_accum #(.IN_W(20), .ACC_W(32), .FIFO_DEPTH(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .cfg_beats(cfg_beats),
    .clear(clear), .out_valid(ov32), .out_ready(out_ready), .out_data(od32),
    .busy(busy32), .ovf(ovf32), .fifo_cnt(fc32));

  dot_accum #(.IN_W(20), .ACC_W(20), .FIFO_DEPTH(4)) u_dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .cfg_beats(cfg_beats),
    .clear(clear), .out_valid(ov20), .out_ready(out_ready), .out_data(od20),
    .busy(busy20), .ovf(ovf20), .fifo_cnt(fc20));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: running sums as plain integers, results as queues.
  longint q32[$];
  longint q20[$];
  longint a32, a20;
  int     mcnt, mn;
  bit     movf, started;
  bit     m_pop, m_push, m_full;

  function automatic longint fold(input longint x, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef DOTACC_SAT_EN
    return (x > mx) ? mx : x;
`else
    return x & mx;
`endif
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      q32.delete(); q20.delete();
      a32 = 0; a20 = 0; mcnt = 0; mn = 0; movf = 1'b0;
    end else begin
      m_pop  = (q32.size() != 0) && out_ready;
      m_full = (q32.size() == 4);
      m_push = 1'b0;
      if (clear) begin
        mcnt = 0; a32 = 0; a20 = 0; movf = 1'b0;
      end else if (in_valid) begin
        if (mcnt == 0) begin
          mn  = (cfg_beats == 0) ? 256 : int'(cfg_beats);
          a32 = longint'(in_sum);
          a20 = longint'(in_sum);
        end else begin
          a32 = fold(a32 + longint'(in_sum), 32);
          a20 = fold(a20 + longint'(in_sum), 20);
        end
        mcnt++;
        if (mcnt == mn) begin
          m_push = 1'b1;
          mcnt   = 0;
        end
      end
      if (m_pop) begin
        void'(q32.pop_front());
        void'(q20.pop_front());
      end
      if (m_push) begin
        if (m_full && !m_pop) movf = 1'b1;
        else begin
          q32.push_back(a32);
          q20.push_back(a20);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid32", longint'(ov32), longint'(q32.size() != 0));
      chk("fifo_cnt32",  longint'(fc32), longint'(q32.size()));
      chk("out_data32",  longint'(od32), (q32.size() != 0) ? q32[0] : 0);
      chk("busy32",      longint'(busy32), longint'(mcnt != 0));
      chk("ovf32",       longint'(ovf32), longint'(movf));
      chk("out_valid20", longint'(ov20), longint'(q20.size() != 0));
      chk("fifo_cnt20",  longint'(fc20), longint'(q20.size()));
      chk("out_data20",  longint'(od20), (q20.size() != 0) ? q20[0] : 0);
      chk("busy20",      longint'(busy20), longint'(mcnt != 0));
      chk("ovf20",       longint'(ovf20), longint'(movf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [19:0] s, input logic [7:0] c);
    in_valid = 1'b1; in_sum = s; cfg_beats = c;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; cfg_beats = 8'd1; clear = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", longint'(ov32), 0);
    chk("rst_out_data",  longint'(od32), 0);
    chk("rst_busy",      longint'(busy32), 0);
    chk("rst_ovf",       longint'(ovf32), 0);
    chk("rst_fifo_cnt",  longint'(fc32), 0);

    // Four back-to-back beats.
    beat(20'd100, 8'd4);
    chk("s1_busy_after_first", longint'(busy32), 1);
    beat(20'd200, 8'd4);
    beat(20'd300, 8'd4);
    chk("s1_no_result_yet", longint'(ov32), 0);
    beat(20'd400, 8'd4);
    chk("s1_out_valid", longint'(ov32), 1);
    chk("s1_out_data",  longint'(od32), 1000);
    chk("s1_fifo_cnt",  longint'(fc32), 1);
    chk("s1_busy_done", longint'(busy32), 0);
    pop_one();
    chk("s1_drained", longint'(fc32), 0);

    // 256-beat vector with consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) beat(20'd1040400, 8'd0);
    chk("s2_out_data", longint'(od32), 266342400);
    chk("s2_ovf",      longint'(ovf32), 0);
    step();
    out_ready = 1'b0;

    // Overflow: five single-beat results into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) beat(20'(i), 8'd1);
    chk("s3_fifo_full", longint'(fc32), 4);
    chk("s3_ovf",       longint'(ovf32), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("s3_drain", longint'(od32), longint'(i));
      pop_one();
    end
    clear = 1'b1; step(); clear = 1'b0;
    chk("s3_ovf_cleared", longint'(ovf32), 0);
    for (int i = 1; i <= 4; i++) beat(20'(i), 8'd1);
    out_ready = 1'b1;
    beat(20'd5, 8'd1);
    out_ready = 1'b0;
    chk("s3b_fifo_cnt", longint'(fc32), 4);
    chk("s3b_ovf",      longint'(ovf32), 0);
    for (int i = 2; i <= 5; i++) begin
      chk("s3b_drain", longint'(od32), longint'(i));
      pop_one();
    end

    // Clear aborts a partial vector and discards the coincident beat.
    beat(20'd7, 8'd3);
    beat(20'd9, 8'd3);
    clear = 1'b1; beat(20'd100, 8'd3); clear = 1'b0;
    chk("s4_busy_after_clear", longint'(busy32), 0);
    beat(20'd1, 8'd3); beat(20'd2, 8'd3); beat(20'd3, 8'd3);
    chk("s4_fifo_cnt", longint'(fc32), 1);
    chk("s4_out_data", longint'(od32), 6);
    pop_one();

    // cfg_beats change mid-vector only affects the next vector.
    beat(20'd10, 8'd2);
    beat(20'd20, 8'd5);
    for (int i = 1; i <= 5; i++) beat(20'(i), 8'd5);
    chk("s5_fifo_cnt", longint'(fc32), 2);
    chk("s5_first",    longint'(od32), 30);
    pop_one();
    chk("s5_second",   longint'(od32), 15);
    pop_one();

    // 20-bit accumulator: wrap or saturate.
    beat(20'd1040400, 8'd2);
    beat(20'd1040400, 8'd2);
    chk("s6_out_data32", longint'(od32), 2080800);
`ifdef DOTACC_SAT_EN
    chk("s6_out_data20", longint'(od20), 1048575);
`else
    chk("s6_out_data20", longint'(od20), 1032224);
`endif
    pop_one();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sum    = 20'($urandom);
      cfg_beats = ($urandom_range(0, 99) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      clear     = ($urandom_range(0, 39) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end
    rst = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
